// File: rtl/nibble_serial_sub_ctrl_pkg.sv
// Shared types and constants for the nibble-serial subtract controller.
package nibble_serial_sub_ctrl_pkg;

  // Width of the single shared subtract slice.
  localparam int NIBBLE_W = 4;

  // Controller sequencing states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Nibble index width: clog2 of the nibble count, never narrower than one bit.
  function automatic int idx_width(input int nibbles);
    return (nibbles > 1) ? $clog2(nibbles) : 1;
  endfunction

endpackage

// File: rtl/nibble_serial_sub_ctrl_if.sv
// Operand/result handshake bundle between an operand source, the controller
// and a result consumer.
interface nibble_serial_sub_ctrl_if #(
  parameter int NIBBLES = 4
) ();
  localparam int W = 4 * NIBBLES;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         borrow_in;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] diff;
  logic         borrow_out;
  logic         zero;
  logic         busy;

  // Operand source and result consumer side.
  modport master (
    output in_valid, a, b, borrow_in, out_ready,
    input  in_ready, out_valid, diff, borrow_out, zero, busy
  );

  // Controller side.
  modport slave (
    input  in_valid, a, b, borrow_in, out_ready,
    output in_ready, out_valid, diff, borrow_out, zero, busy
  );
endinterface

// File: rtl/nibble_serial_sub_ctrl_slice.sv
// Combinational 4-bit subtract slice: a + ~b + ~borrow_in, built as a
// ripple of full adders. The carry out is the inverted nibble borrow.
module nibble_sub_slice
  import nibble_serial_sub_ctrl_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                borrow_in,
  output logic [NIBBLE_W-1:0] diff,
  output logic                borrow_out
);

  logic [NIBBLE_W:0]   carry;
  logic [NIBBLE_W-1:0] b_inv;

  assign b_inv    = ~b;
  assign carry[0] = ~borrow_in;

  for (genvar i = 0; i < NIBBLE_W; i++) begin : g_fa
    assign diff[i]    = a[i] ^ b_inv[i] ^ carry[i];
    assign carry[i+1] = (a[i] & b_inv[i]) | (a[i] & carry[i]) | (b_inv[i] & carry[i]);
  end

  assign borrow_out = ~carry[NIBBLE_W];

endmodule

// File: rtl/nibble_serial_sub_ctrl.sv
// Wide unsigned subtractor (a - b - borrow_in) that reuses one 4-bit slice,
// processing one nibble per clock, least significant nibble first.
module nibble_serial_sub_ctrl
  import nibble_serial_sub_ctrl_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input logic                    clk,
  input logic                    rst_n,
  nibble_serial_sub_ctrl_if.slave bus
);

  localparam int W     = NIBBLE_W * NIBBLES;
  localparam int IDX_W = idx_width(NIBBLES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  state_t             state;
  state_t             next_state;
  logic [IDX_W-1:0]   idx;
  logic [W-1:0]       a_sh;
  logic [W-1:0]       b_sh;
  logic [W-1:0]       res_acc;
  logic [W-1:0]       res_next;
  logic [W-1:0]       diff_q;
  logic               borrow_q;
  logic               borrow_out_q;
  logic               zero_q;
  logic               in_ready;
  logic               accept;
  logic               out_valid;
  logic               busy;
  logic               last_nib;
  logic [NIBBLE_W-1:0] slice_d;
  logic               slice_borrow;

  // The one shared datapath slice always sees the low nibble of the shifters.
  nibble_sub_slice u_slice (
    .a          (a_sh[NIBBLE_W-1:0]),
    .b          (b_sh[NIBBLE_W-1:0]),
    .borrow_in  (borrow_q),
    .diff       (slice_d),
    .borrow_out (slice_borrow)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state logic; a DONE with a same-edge accept skips IDLE entirely.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (accept) next_state = RUN;
      RUN:  if (last_nib) next_state = DONE;
      DONE: begin
        if (accept)             next_state = RUN;
        else if (bus.out_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Handshake and status decode from the current state.
  always_comb begin
    in_ready  = (state == IDLE) || ((state == DONE) && bus.out_ready);
    accept    = bus.in_valid && in_ready;
    out_valid = (state == DONE);
    busy      = (state == RUN);
    last_nib  = (state == RUN) && (idx == LAST_IDX);
  end

  // Merge the current slice result into the partially assembled difference.
  always_comb begin
    res_next = res_acc;
    for (int i = 0; i < NIBBLES; i++) begin
      if (idx == IDX_W'(i)) res_next[i*NIBBLE_W +: NIBBLE_W] = slice_d;
    end
  end

  // Operand shifting, borrow chaining and result capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh         <= '0;
      b_sh         <= '0;
      borrow_q     <= 1'b0;
      idx          <= '0;
      res_acc      <= '0;
      diff_q       <= '0;
      borrow_out_q <= 1'b0;
      zero_q       <= 1'b0;
    end else if (accept) begin
      a_sh     <= bus.a;
      b_sh     <= bus.b;
      borrow_q <= bus.borrow_in;
      idx      <= '0;
      res_acc  <= '0;
    end else if (state == RUN) begin
      a_sh     <= a_sh >> NIBBLE_W;
      b_sh     <= b_sh >> NIBBLE_W;
      borrow_q <= slice_borrow;
      idx      <= idx + 1'b1;
      res_acc  <= res_next;
      if (last_nib) begin
        // Visible result changes only here, so it holds through DONE and
        // after consumption until the next operation completes.
        diff_q       <= res_next;
        borrow_out_q <= slice_borrow;
        zero_q       <= (res_next == '0);
      end
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = out_valid;
  assign bus.busy       = busy;
  assign bus.diff       = diff_q;
  assign bus.borrow_out = borrow_out_q;
  assign bus.zero       = zero_q;

endmodule
